pic_ctl: RTL and testbench



---
 rtl/pic_pkg.sv | 18 +
 rtl/pic_prio_enc.sv | 26 ++
 rtl/pic_ctl.sv | 182 ++++++++++++++++++
 tb/tb_pic_ctl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the programmable interrupt controller.
//   - command byte values written to the command port
//   - bit positions of the EOI and specific-EOI flags in a command byte
//   - encoding of which register a command-port read returns
package pic_pkg;

    localparam logic [7:0] PIC_CMD_READ_IRR = 8'h0A;
    localparam logic [7:0] PIC_CMD_READ_ISR = 8'h0B;
    localparam int         PIC_EOI_BIT      = 5;
    localparam int         PIC_SPECIFIC_BIT = 6;

    // Selects what a read of the command port returns.
    typedef enum logic {
        SEL_IRR = 1'b0,
        SEL_ISR = 1'b1
    } pic_read_sel_e;

endpackage

// File: rtl/pic_prio_enc.sv
// Lowest-set-bit encoder (bit 0 has highest priority).
// Ports:
//   req    in  IRQ_COUNT  request vector
//   index  out 3          index of the lowest set bit (0 when none set)
//   valid  out 1          at least one bit of req is set
module pic_prio_enc #(
    parameter int IRQ_COUNT = 8
) (
    input  logic [IRQ_COUNT-1:0] req,
    output logic [2:0]           index,
    output logic                 valid
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        index = 3'd0;
        valid = 1'b0;
        for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = 3'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pic_ctl.sv
// Programmable interrupt controller on the CPU port bus.
// Latches rising edges on up to 8 request lines (IRR), applies a mask (IMR),
// resolves fixed priority with nested in-service tracking (ISR) and delivers
// one vector at a time via a toggle handshake.
// Ports:
//   clock_cpu     in  1          CPU clock, all logic on posedge
//   reset         in  1          synchronous active-high reset
//   port_address  in  16         CPU port address
//   port_out      in  8          CPU write data
//   port_write    in  1          write strobe (one cycle per access)
//   port_read     in  1          read strobe (one cycle per access)
//   port_in       out 8          registered read data
//   irq_lines     in  IRQ_COUNT  request lines, synchronous to clock_cpu
//   irq_signal    out 1          toggles once per delivered interrupt
//   irq           out 8          vector of the most recent delivery
module pic_ctl
    import pic_pkg::*;
#(
    parameter int          IRQ_COUNT   = 8,
    parameter logic [7:0]  VECTOR_BASE = 8'h08,
    parameter logic [15:0] PORT_BASE   = 16'h0020,
    parameter logic [7:0]  MASK_RESET  = 8'hFC
) (
    input  logic                 clock_cpu,
    input  logic                 reset,
    input  logic [15:0]          port_address,
    input  logic [7:0]           port_out,
    input  logic                 port_write,
    input  logic                 port_read,
    output logic [7:0]           port_in,
    input  logic [IRQ_COUNT-1:0] irq_lines,
    output logic                 irq_signal,
    output logic [7:0]           irq
);

    logic [IRQ_COUNT-1:0] irr_reg, irr_next;
    logic [IRQ_COUNT-1:0] isr_reg, isr_next;
    logic [IRQ_COUNT-1:0] imr_reg, imr_next;
    logic [IRQ_COUNT-1:0] line_prev_reg;
    pic_read_sel_e        read_sel_reg, read_sel_next;
    logic [7:0]           port_in_reg, port_in_next;
    logic                 irq_signal_reg, irq_signal_next;
    logic [7:0]           irq_reg, irq_next;

    logic [IRQ_COUNT-1:0] line_rise;
    logic [IRQ_COUNT-1:0] cand_req;
    logic [2:0]           cand_idx;
    logic                 cand_valid;
    logic                 cand_blocked;
    logic                 deliver;
    logic [IRQ_COUNT-1:0] deliver_onehot;
    logic [2:0]           isr_low_idx;
    logic                 isr_low_valid;
    logic [IRQ_COUNT-1:0] eoi_clear;
    logic                 cmd_write;
    logic                 mask_write;
    logic                 is_eoi;
    logic                 is_specific;
    logic [7:0]           irr_ext, isr_ext, imr_ext;

    // Zero-extend the state registers to the 8-bit bus.
    for (genvar gi = 0; gi < 8; gi++) begin : g_ext
        if (gi < IRQ_COUNT) begin : g_used
            assign irr_ext[gi] = irr_reg[gi];
            assign isr_ext[gi] = isr_reg[gi];
            assign imr_ext[gi] = imr_reg[gi];
        end else begin : g_pad
            assign irr_ext[gi] = 1'b0;
            assign isr_ext[gi] = 1'b0;
            assign imr_ext[gi] = 1'b0;
        end
    end

    assign line_rise = irq_lines & ~line_prev_reg;
    assign cand_req  = irr_reg & ~imr_reg;

    pic_prio_enc #(.IRQ_COUNT(IRQ_COUNT)) u_cand_enc (
        .req   (cand_req),
        .index (cand_idx),
        .valid (cand_valid)
    );

    // Lowest in-service line, target of a non-specific EOI.
    pic_prio_enc #(.IRQ_COUNT(IRQ_COUNT)) u_isr_enc (
        .req   (isr_reg),
        .index (isr_low_idx),
        .valid (isr_low_valid)
    );

    // A candidate waits while any line of equal or higher priority is in service.
    always_comb begin
        cand_blocked = 1'b0;
        for (int j = 0; j < IRQ_COUNT; j++) begin
            if (j <= int'(cand_idx) && isr_reg[j]) begin
                cand_blocked = 1'b1;
            end
        end
    end

    assign deliver     = cand_valid && !cand_blocked;
    assign cmd_write   = port_write && (port_address == PORT_BASE);
    assign mask_write  = port_write && (port_address == PORT_BASE + 16'd1);
    assign is_eoi      = cmd_write && (port_out != PIC_CMD_READ_IRR) &&
                         (port_out != PIC_CMD_READ_ISR) && port_out[PIC_EOI_BIT];
    assign is_specific = port_out[PIC_SPECIFIC_BIT];

    always_comb begin
        deliver_onehot = '0;
        eoi_clear      = '0;
        for (int j = 0; j < IRQ_COUNT; j++) begin
            deliver_onehot[j] = deliver && (cand_idx == 3'(j));
            if (is_eoi) begin
                if (is_specific) begin
                    // Indices beyond the implemented lines never match.
                    eoi_clear[j] = (port_out[2:0] == 3'(j));
                end else begin
                    eoi_clear[j] = isr_low_valid && (isr_low_idx == 3'(j));
                end
            end
        end
    end

    always_comb begin
        // Edge set wins over delivery clear on the same line.
        irr_next = (irr_reg & ~deliver_onehot) | line_rise;
        // EOI works from pre-cycle ISR; the delivered bit was clear there.
        isr_next = (isr_reg & ~eoi_clear) | deliver_onehot;

        imr_next = imr_reg;
        if (mask_write) begin
            imr_next = port_out[IRQ_COUNT-1:0];
        end

        read_sel_next = read_sel_reg;
        if (cmd_write && port_out == PIC_CMD_READ_IRR) begin
            read_sel_next = SEL_IRR;
        end else if (cmd_write && port_out == PIC_CMD_READ_ISR) begin
            read_sel_next = SEL_ISR;
        end

        port_in_next = port_in_reg;
        if (port_read && port_address == PORT_BASE) begin
            port_in_next = (read_sel_reg == SEL_ISR) ? isr_ext : irr_ext;
        end else if (port_read && port_address == PORT_BASE + 16'd1) begin
            port_in_next = imr_ext;
        end

        irq_signal_next = irq_signal_reg;
        irq_next        = irq_reg;
        if (deliver) begin
            irq_signal_next = ~irq_signal_reg;
            irq_next        = VECTOR_BASE + {5'd0, cand_idx};
        end
    end

    always_ff @(posedge clock_cpu) begin
        if (reset) begin
            irr_reg        <= '0;
            isr_reg        <= '0;
            imr_reg        <= MASK_RESET[IRQ_COUNT-1:0];
            line_prev_reg  <= '1;
            read_sel_reg   <= SEL_IRR;
            port_in_reg    <= 8'hFF;
            irq_signal_reg <= 1'b0;
            irq_reg        <= 8'h00;
        end else begin
            irr_reg        <= irr_next;
            isr_reg        <= isr_next;
            imr_reg        <= imr_next;
            line_prev_reg  <= irq_lines;
            read_sel_reg   <= read_sel_next;
            port_in_reg    <= port_in_next;
            irq_signal_reg <= irq_signal_next;
            irq_reg        <= irq_next;
        end
    end

    assign port_in    = port_in_reg;
    assign irq_signal = irq_signal_reg;
    assign irq        = irq_reg;

endmodule

// File: tb/tb_pic_ctl.sv
module tb_pic_ctl;

    localparam logic [15:0] PB = 16'h0020;
    localparam logic [15:0] PM = 16'h0021;

    logic        clock_cpu = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] port_address = 16'h0000;
    logic [7:0]  port_out = 8'h00;
    logic        port_write = 1'b0;
    logic        port_read = 1'b0;
    logic [7:0]  port_in;
    logic [7:0]  irq_lines = 8'h00;
    logic        irq_signal;
    logic [7:0]  irq;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] dlv_q[$];   // expected vectors, in delivery order
    logic [7:0] rd_q[$];    // expected read data, in read order

    pic_ctl dut (
        .clock_cpu    (clock_cpu),
        .reset        (reset),
        .port_address (port_address),
        .port_out     (port_out),
        .port_write   (port_write),
        .port_read    (port_read),
        .port_in      (port_in),
        .irq_lines    (irq_lines),
        .irq_signal   (irq_signal),
        .irq          (irq)
    );

    always #5 clock_cpu = ~clock_cpu;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end else begin
            $display("ok   %s: %02h", tag, got);
        end
    endtask

    // Scoreboard monitor: each toggle pops a vector, each read pops a value.
    logic sig_prev = 1'b0;
    always @(posedge clock_cpu) begin
        logic rst_e;
        logic rd_e;
        logic [7:0] e;
        rst_e = reset;
        rd_e  = port_read;
        #1;
        if (!rst_e && irq_signal !== sig_prev) begin
            check_val("dlv_pending", {7'd0, dlv_q.size() != 0}, 8'd1);
            if (dlv_q.size() != 0) begin
                e = dlv_q.pop_front();
                check_val("irq_vec", irq, e);
            end
        end
        sig_prev = irq_signal;
        if (!rst_e && rd_e) begin
            check_val("rd_pending", {7'd0, rd_q.size() != 0}, 8'd1);
            if (rd_q.size() != 0) begin
                e = rd_q.pop_front();
                check_val("port_in", port_in, e);
            end
        end
    end

    task automatic tick();
        @(posedge clock_cpu);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        port_address = a;
        port_out     = d;
        port_write   = 1'b1;
        tick();
        port_write   = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] exp);
        rd_q.push_back(exp);
        port_address = a;
        port_read    = 1'b1;
        tick();
        port_read    = 1'b0;
    endtask

    // One-cycle pulse on the given lines, then two idle cycles.
    task automatic pulse(input logic [7:0] m);
        irq_lines = m;
        tick();
        irq_lines = 8'h00;
        tick();
        tick();
    endtask

    initial begin
        logic s0;
        // Reset
        tick();
        tick();
        reset = 1'b0;
        check_val("rst_port_in", port_in, 8'hFF);
        check_val("rst_sig", {7'd0, irq_signal}, 8'd0);
        check_val("rst_irq", irq, 8'h00);
        rd(PM, 8'hFC);
        rd(PB, 8'h00);

        // Basic delivery and latency on line 1
        wr(PM, 8'h00);
        dlv_q.push_back(8'h09);
        s0 = irq_signal;
        irq_lines = 8'h02;
        tick();
        check_val("lat1_sig", {7'd0, irq_signal}, {7'd0, s0});
        irq_lines = 8'h00;
        tick();
        check_val("lat2_sig", {7'd0, irq_signal}, {7'd0, ~s0});
        wr(PB, 8'h0B);
        rd(PB, 8'h02);
        wr(PB, 8'h20);
        rd(PB, 8'h00);

        // Nesting: line 3 in service, line 0 preempts
        dlv_q.push_back(8'h0B);
        pulse(8'h08);
        dlv_q.push_back(8'h08);
        pulse(8'h01);
        rd(PB, 8'h09);
        wr(PB, 8'h20);
        rd(PB, 8'h08);
        wr(PB, 8'h20);
        rd(PB, 8'h00);

        // Equal and lower priority wait for EOI
        dlv_q.push_back(8'h09);
        pulse(8'h02);
        s0 = irq_signal;
        pulse(8'h12);
        tick();
        check_val("blocked_sig", {7'd0, irq_signal}, {7'd0, s0});
        dlv_q.push_back(8'h09);
        wr(PB, 8'h20);
        tick();
        tick();
        tick();
        dlv_q.push_back(8'h0C);
        wr(PB, 8'h20);
        tick();
        tick();
        rd(PB, 8'h10);
        wr(PB, 8'h20);
        rd(PB, 8'h00);

        // Masking, simultaneous edges, unmask then nested delivery
        wr(PM, 8'h04);
        dlv_q.push_back(8'h0D);
        pulse(8'h24);
        wr(PB, 8'h0A);
        rd(PB, 8'h04);
        rd(PM, 8'h04);
        dlv_q.push_back(8'h0A);
        wr(PM, 8'h00);
        tick();
        tick();
        wr(PB, 8'h0B);
        rd(PB, 8'h24);
        wr(PB, 8'h20);
        wr(PB, 8'h20);
        rd(PB, 8'h00);

        // Specific EOI
        dlv_q.push_back(8'h09);
        pulse(8'h02);
        dlv_q.push_back(8'h08);
        pulse(8'h01);
        wr(PB, 8'h61);
        rd(PB, 8'h01);
        wr(PB, 8'h67);
        rd(PB, 8'h01);
        wr(PB, 8'h20);
        rd(PB, 8'h00);

        // Reset mid-service discards everything
        wr(PB, 8'h0A);
        dlv_q.push_back(8'h09);
        pulse(8'h02);
        pulse(8'h10);
        rd(PB, 8'h10);
        wr(PB, 8'h0B);
        rd(PB, 8'h02);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("rst2_sig", {7'd0, irq_signal}, 8'd0);
        check_val("rst2_irq", irq, 8'h00);
        rd(PM, 8'hFC);
        rd(PB, 8'h00);
        wr(PM, 8'h00);
        tick();
        tick();
        tick();
        wr(PB, 8'h0B);
        rd(PB, 8'h00);
        check_val("rst2_sig_idle", {7'd0, irq_signal}, 8'd0);

        tick();
        check_val("dlv_q_left", 8'(dlv_q.size()), 8'd0);
        check_val("rd_q_left", 8'(rd_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
